// File: rtl/cntb_run_scan_if.sv
// Request/result bundle between the custom-instruction issue logic and the
// run-length scanner.
interface cntb_run_scan_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned POS_W = $clog2(XLEN);
  localparam int unsigned CNT_W = $clog2(XLEN + 1);

  logic             start_i;
  logic             ready_o;
  logic [XLEN-1:0]  data_i;
  logic [POS_W-1:0] pos_i;
  logic [1:0]       mode_i;
  logic             dir_i;
  logic [CNT_W-1:0] limit_i;
  logic             busy_o;
  logic             valid_o;
  logic [CNT_W-1:0] count_o;
  logic             bit_o;

  modport master (
    output start_i, data_i, pos_i, mode_i, dir_i, limit_i,
    input  ready_o, busy_o, valid_o, count_o, bit_o
  );

  modport slave (
    input  start_i, data_i, pos_i, mode_i, dir_i, limit_i,
    output ready_o, busy_o, valid_o, count_o, bit_o
  );
endinterface

// File: rtl/cntb_run_scan.sv
// Multi-cycle run-length scanner: counts consecutive bits equal to a target,
// starting at a chosen index and walking CHUNK bits per cycle toward LSB or MSB.
module cntb_run_scan #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  cntb_run_scan_if.slave bus
);
  localparam int unsigned POS_W = $clog2(XLEN);
  localparam int unsigned CNT_W = $clog2(XLEN + 1);
  localparam int unsigned RUN_W = $clog2(CHUNK + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q,  state_d;
  logic [XLEN-1:0]  data_q,   data_d;
  logic [POS_W-1:0] cursor_q, cursor_d;
  logic             dir_q,    dir_d;
  logic             target_q, target_d;
  logic [CNT_W-1:0] limit_q,  limit_d;
  logic [CNT_W-1:0] acc_q,    acc_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             bit_q,    bit_d;
  logic             ready_q,  ready_d;
  logic             busy_q,   busy_d;
  logic             valid_q,  valid_d;

  logic [CHUNK-1:0] match_c;
  logic [RUN_W-1:0] run_c;
  logic             run_open_c;
  logic [SUM_W-1:0] sum_c;
  logic             edge_c;
  logic             limit_hit_c;
  logic [CNT_W-1:0] acc_next_c;
  logic             tgt_in_c;
  logic             accept_c;

  // Window compare; positions past either end of the operand never match.
  always_comb begin
    match_c = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (dir_q) begin
        if (cursor_q <= POS_W'(XLEN - 1 - i)) begin
          match_c[i] = (data_q[cursor_q + POS_W'(i)] == target_q);
        end
      end else if (cursor_q >= POS_W'(i)) begin
        match_c[i] = (data_q[cursor_q - POS_W'(i)] == target_q);
      end
    end
  end

  // Leading-match count of the window.
  always_comb begin
    run_c      = '0;
    run_open_c = 1'b1;
    for (int i = 0; i < CHUNK; i++) begin
      run_open_c = run_open_c & match_c[i];
      if (run_open_c) begin
        run_c = run_c + RUN_W'(1);
      end
    end
  end

  assign edge_c      = dir_q ? (cursor_q >= POS_W'(XLEN - CHUNK))
                             : (cursor_q <= POS_W'(CHUNK - 1));
  assign sum_c       = SUM_W'(acc_q) + SUM_W'(run_c);
  assign limit_hit_c = (limit_q != '0) && (sum_c >= SUM_W'(limit_q));
  assign acc_next_c  = limit_hit_c ? limit_q : sum_c[CNT_W-1:0];

  always_comb begin
    unique case (bus.mode_i)
      2'b01:   tgt_in_c = 1'b1;
      2'b10:   tgt_in_c = 1'b0;
      default: tgt_in_c = bus.data_i[bus.pos_i];
    endcase
  end

  assign accept_c = bus.start_i && ((state_q == IDLE) || (state_q == DONE));

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    cursor_d = cursor_q;
    dir_d    = dir_q;
    target_d = target_q;
    limit_d  = limit_q;
    acc_d    = acc_q;
    count_d  = count_q;
    bit_d    = bit_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (accept_c) begin
          data_d   = bus.data_i;
          cursor_d = bus.pos_i;
          dir_d    = bus.dir_i;
          target_d = tgt_in_c;
          limit_d  = bus.limit_i;
          acc_d    = '0;
          state_d  = SCAN;
        end else begin
          state_d  = IDLE;
        end
      end
      SCAN: begin
        acc_d    = acc_next_c;
        cursor_d = dir_q ? (cursor_q + POS_W'(CHUNK)) : (cursor_q - POS_W'(CHUNK));
        if ((run_c < RUN_W'(CHUNK)) || edge_c || limit_hit_c) begin
          count_d = acc_next_c;
          bit_d   = target_q;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d != SCAN);
    busy_d  = (state_d == SCAN);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      data_q   <= '0;
      cursor_q <= '0;
      dir_q    <= 1'b0;
      target_q <= 1'b0;
      limit_q  <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      bit_q    <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      cursor_q <= cursor_d;
      dir_q    <= dir_d;
      target_q <= target_d;
      limit_q  <= limit_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      bit_q    <= bit_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.ready_o = ready_q;
  assign bus.busy_o  = busy_q;
  assign bus.valid_o = valid_q;
  assign bus.count_o = count_q;
  assign bus.bit_o   = bit_q;

endmodule
